// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice is reused
// once per clock, least-significant nibble first, with a registered carry
// between nibbles. Also contains the 4-bit slice it is built around.

module carrylookaheadadder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate carry lookahead across the four bits.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module cla_nibble_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {StIdle, StAdd} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] acc_upd;
    logic             last;

    // Select nibble idx of each operand by shifting it down to bit 0.
    always_comb begin
        sh_a  = opa >> {idx, 2'b00};
        sh_b  = opb >> {idx, 2'b00};
        nib_a = sh_a[3:0];
        nib_b = sh_b[3:0];
        last  = (idx == IW'(NIB - 1));
    end

    carrylookaheadadder u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Accumulator with nibble idx replaced by this cycle's slice sum; on the
    // final nibble this is the complete result.
    always_comb begin
        acc_upd = acc;
        for (int i = 0; i < int'(NIB); i++) begin
            if (idx == IW'(i)) begin
                acc_upd[4*i +: 4] = slice_sum;
            end
        end
    end

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= StAdd;
                    end
                end
                StAdd: begin
                    acc   <= acc_upd;
                    carry <= slice_cout;
                    if (last) begin
                        sum   <= acc_upd;
                        cout  <= slice_cout;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: doc/cla_nibble_sequencer.md
# cla_nibble_sequencer

Multi-cycle wide adder built around the team's 4-bit `carrylookaheadadder` slice. The block instantiates exactly one slice and sequences it one nibble per clock to produce a WIDTH-bit sum. A registered carry links the nibbles, least-significant first. It sits between a requester issuing `start` with operands and any consumer of the `done`-qualified result. It trades latency for area versus a full-width adder.

## Interface
- `WIDTH`, default 16: operand/result width. Must be a multiple of 4 and at least 4. NIB = WIDTH/4 nibbles.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Sampled only while `busy`=0.
- `a`  in  WIDTH  operand A. Captured on the accepting edge.
- `b`  in  WIDTH  operand B. Captured on the accepting edge.
- `cin`  in  1  carry-in. Captured on the accepting edge.
- `busy`  out  1  high while an addition is in progress.
- `done`  out  1  one-cycle pulse: `sum`/`cout` just updated.
- `sum`  out  WIDTH  result. Held until the next completion.
- `cout`  out  1  carry out of the MSB nibble. Held with `sum`.

## Operation
- States: IDLE, ADD.
- Internal registers: `opa`, `opb` (WIDTH each), `acc` (WIDTH), `carry` (1), `idx` (ceil(log2(NIB)) bits, minimum 1).
- Single slice instance. Slice inputs are nibble `idx` of `opa`, nibble `idx` of `opb`, and `carry`. Nibble `idx` means bits [4*idx+3 : 4*idx].
- IDLE with `start`=1 at an edge:
  - Latch `a`/`b` into `opa`/`opb`.
  - Set `carry`<=`cin`, `idx`<=0, `busy`<=1.
  - Go to ADD.
- IDLE with `start`=0: hold all registers.
- ADD, each edge:
  - Write slice sum into nibble `idx` of `acc`.
  - Set `carry`<=slice cout.
- ADD with `idx`<NIB-1: `idx`<=`idx`+1, stay in ADD.
- ADD with `idx`=NIB-1 (final edge):
  - Load `sum` <= `acc` with the top nibble replaced by this cycle's slice sum.
  - Load `cout` <= slice cout.
  - Set `done`<=1, `busy`<=0, go to IDLE.
- `done` is cleared on every edge where it is not being set.
- `start` while `busy`=1 is ignored. It is not queued and does not disturb the operation in flight.
- Arithmetic: the result is the full unsigned sum {`cout`,`sum`} = `a` + `b` + `cin`, modulo 2^(WIDTH+1). No signed overflow flag.
- `sum`/`cout` change only at a completion edge or at reset. Partial results are never visible on outputs.
- Changes to `a`/`b`/`cin` after acceptance have no effect.

## Timing
- Reset (asynchronous): state IDLE; `idx`, `carry`, `opa`, `opb`, `acc` all 0; outputs `busy`=0, `done`=0, `sum`=0, `cout`=0.
- Reset asserted mid-operation: abort immediately to the reset values above. No `done` is produced; the prior `sum`/`cout` are lost (read 0).
- Latency: `start` accepted at edge E0 → `done`=1 and new `sum`/`cout` after edge E(NIB). Example: 4 cycles for WIDTH=16, 1 cycle for WIDTH=4.
- `busy` is high after E0 through E(NIB), and low after E(NIB).
- Throughput: one operation per NIB+1 cycles when `start` is held high continuously.
  - In the cycle `done`=1, `busy`=0, so `start` is accepted at the next edge.
  - The result stays stable during that next operation.
- Minimum `done` spacing is NIB+1 cycles.
- Carry path is registered between nibbles. The critical path is one 4-bit CLA slice plus the nibble mux.

## Test plan
- WIDTH=16, `a`=0x1234, `b`=0x4321, `cin`=0, start pulse → `busy` high 4 cycles; `done` one cycle after edge 4; `sum`=0x5555, `cout`=0.
- WIDTH=16, `a`=0xFFFF, `b`=0x0001, `cin`=0 → `sum`=0x0000, `cout`=1, verifying carry propagation through all four nibbles. Then `a`=0xFFFF, `b`=0xFFFF, `cin`=1 → `sum`=0xFFFF, `cout`=1.
- `start`=1 held continuously with operands changing every cycle → only operands sampled at acceptance edges are used; `done` pulses every 5 cycles; `sum` matches the reference model for each accepted pair.
- During an operation on 0x00F0+0x0010, pulse `start` with 0xAAAA+0x5555 at cycle 2 → ignored; result 0x0100, `cout`=0; no extra `done`.
- Complete 0x1111+0x1111 (`sum`=0x2222), start 0x0FFF+0x0001, then assert `rst` after 2 cycles → all outputs 0 immediately; no `done`. Then a new start with 0x0FFF+0x0001 → `sum`=0x1000.
- WIDTH=4: `a`=5, `b`=6, `cin`=1 → `done` after 1 cycle, `sum`=12, `cout`=0. Then `a`=4, `b`=10, `cin`=1 → `sum`=15, `cout`=0. Then `a`=15, `b`=1, `cin`=0 → `sum`=0, `cout`=1.
